// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit microcpu; owns pc and instruction register.
// Latency: 3 cycles for non-memory instructions, 5 for loads/stores. Memory ports stall with req/ack.
// Optional handshake timeout with sticky err: define CPU_SEQ_TIMEOUT_EN.
module cpu_sequencer #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    input  logic               cu_load_pc,
    input  logic [PC_W-1:0]    cu_load_pc_val,
    input  logic               cu_reg_we,
    input  logic               cu_mem_rd,
    input  logic               cu_mem_wr,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_we,
    output logic               status_we,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic [2:0]         state,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t               state_q, state_nxt;
    logic [PC_W-1:0]      pc_q, pc_nxt;
    logic [INSTR_W-1:0]   instr_q, instr_nxt;
    logic [3:0]           opcode;
    logic                 undef_op;
    logic                 mem_op;
    logic                 err_q;
    logic                 tmo;

    assign opcode   = instr_q[INSTR_W-1:INSTR_W-4];
    // Undefined opcodes run as a plain pc+1 whatever the control unit asserts.
    assign undef_op = (opcode == 4'b1001) || (opcode >= 4'b1101);
    assign mem_op   = (cu_mem_rd || cu_mem_wr) && !undef_op;

`ifdef CPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_nxt != state_q) begin
            cnt_q <= '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Only a timeout takes a memory-wait state straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && state_nxt == S_IDLE) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign err_q = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        status_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && !err_q) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt = imem_data;
                    state_nxt = S_DECODE;
                end else if (tmo) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (mem_op) begin
                    state_nxt = S_MEM;
                end else begin
                    reg_we    = cu_reg_we && !undef_op;
                    status_we = (opcode == 4'b1010);
                    pc_nxt    = (cu_load_pc && !undef_op) ? cu_load_pc_val : pc_q + PC_W'(1);
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cu_mem_wr;
                if (dmem_ack) begin
                    state_nxt = S_WB;
                end else if (tmo) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                reg_we    = cu_reg_we && !undef_op;
                pc_nxt    = pc_q + PC_W'(1);
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign busy      = (state_q != S_IDLE);
    assign state     = state_q;
    assign err       = err_q;

endmodule
